dump_ctrl: RTL

Sequences a channel dump out of the capture RAM after a trace has been captured. On a dump request it reads the 512 stored samples of one channel, oldest first, starting just after the trace end address. Each byte goes to the UART transmitter with a trmt/tx_done handshake, and dump_fin is pulsed when the last byte has been sent. It sits between the command processor (dump, ch_sel), the capture controller (trace_end, cap_busy), the three channel RAMs and the UART transmitter.

---
 rtl/dump_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dump_ctrl.sv
// dump_ctrl: streams one channel of the capture RAM, oldest sample first,
// to the UART transmitter after a trace has been captured.
module dump_ctrl #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump,
  input  logic [1:0]    ch_sel,
  input  logic [AW-1:0] trace_end,
  input  logic          cap_busy,
  output logic [2:0]    rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rdata,
  output logic [7:0]    tx_data,
  output logic          trmt,
  input  logic          tx_done,
  output logic          dump_fin,
  output logic          dump_err,
  output logic          busy
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PEND  = 3'd1,
    RD    = 3'd2,
    LATCH = 3'd3,
    TXW   = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          trmt_q, trmt_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= 2'b00;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      tx_data_q <= 8'h00;
      trmt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    tx_data_d = tx_data_q;
    trmt_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump) begin
          ch_d   = ch_sel;
          addr_d = trace_end + AW'(1);
          cnt_d  = '0;
          if (ch_sel == 2'b11) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            err_d   = 1'b0;
            state_d = cap_busy ? PEND : RD;
          end
        end
      end
      PEND: begin
        if (!cap_busy) state_d = RD;
      end
      RD: begin
        state_d = LATCH;
      end
      LATCH: begin
        tx_data_d = rdata;
        trmt_d    = 1'b1;
        state_d   = TXW;
      end
      TXW: begin
        if (tx_done) begin
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_d = FIN;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            addr_d  = addr_q + AW'(1);
            state_d = RD;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    rd_en    = (state_q == RD) ? (3'b001 << ch_q) : 3'b000;
    rd_addr  = addr_q;
    dump_fin = (state_q == FIN);
    busy     = (state_q != IDLE);
    tx_data  = tx_data_q;
    trmt     = trmt_q;
    dump_err = err_q;
  end

endmodule
